// File: rtl/ddr2_host_req_sequencer.sv
// ddr2_host_req_sequencer: turns host requests into held ddr2_controller CMD/SZ/OP/ADDR/DIN inputs.
// Latency: a scalar request drives CMD one cycle after acceptance; a BLW drives CMD one cycle after its last payload word.
// Backpressure: CMD is held until NOTFULL/FILLCOUNT show it consumed; BLW data advances only while FILLCOUNT<=FILL_LIMIT.
// Optional feature macro: DDR2_SEQ_PERF_CNT_EN enables the saturating ISSUE_CNT/STALL_CNT counters.
module ddr2_host_req_sequencer #(
  parameter int ADDR_W     = 25,
  parameter int DATA_W     = 16,
  parameter int FILL_LIMIT = 63
) (
  input  logic              CLK,
  input  logic              RESETBAR,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [2:0]        REQ_CMD,
  input  logic [1:0]        REQ_SZ,
  input  logic [2:0]        REQ_OP,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [DATA_W-1:0] REQ_DATA,
  input  logic              WDATA_VALID,
  output logic              WDATA_READY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic              CTRL_READY,
  input  logic              NOTFULL,
  input  logic [6:0]        FILLCOUNT,
  output logic [2:0]        CMD,
  output logic [1:0]        SZ,
  output logic [2:0]        OP,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] DIN,
  output logic              BUSY,
  output logic [15:0]       ISSUE_CNT,
  output logic [15:0]       STALL_CNT
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COLLECT  = 2'd1,
    S_ISSUE    = 2'd2,
    S_BLK_DATA = 2'd3
  } state_t;

  localparam logic [2:0] C_SCR = 3'd1;
  localparam logic [2:0] C_SCW = 3'd2;
  localparam logic [2:0] C_BLR = 3'd3;
  localparam logic [2:0] C_BLW = 3'd4;
  localparam logic [2:0] C_ATR = 3'd5;
  localparam logic [2:0] C_ATW = 3'd6;
  localparam logic [6:0] LP_FILL_LIMIT = 7'(FILL_LIMIT);

  state_t            r_state;
  logic              r_live;
  logic [2:0]        r_cmd;
  logic [1:0]        r_sz;
  logic [2:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_din;
  logic [1:0]        r_blw_sz;
  logic [ADDR_W-1:0] r_blw_addr;
  logic [4:0]        r_wptr;
  logic [4:0]        r_rptr;
  logic [DATA_W-1:0] r_buf [32];

  logic              w_req_hs;
  logic              w_wdat_hs;
  logic              w_fill_ok;
  logic              w_is_rd;
  logic              w_consume;
  logic [4:0]        w_last_idx;

  // r_live keeps REQ_READY low while reset is asserted even though IDLE is the reset state
  assign REQ_READY   = r_live && (r_state == S_IDLE) && CTRL_READY;
  assign WDATA_READY = (r_state == S_COLLECT);
  assign BUSY        = (r_state != S_IDLE);

  assign w_req_hs   = REQ_VALID && REQ_READY;
  assign w_wdat_hs  = WDATA_VALID && WDATA_READY;
  assign w_fill_ok  = (FILLCOUNT <= LP_FILL_LIMIT);
  assign w_is_rd    = (r_cmd == C_SCR) || (r_cmd == C_BLR);
  assign w_consume  = NOTFULL && (w_is_rd || w_fill_ok);
  // Index of the last word of the burst: N-1 = 8*(SZ+1)-1
  assign w_last_idx = {r_blw_sz, 3'b111};

  assign CMD  = r_cmd;
  assign SZ   = r_sz;
  assign OP   = r_op;
  assign ADDR = r_addr;
  assign DIN  = r_din;

  // Sequencer FSM: accept, collect BLW payload, hold command until consumed, stream BLW data
  always_ff @(posedge CLK or negedge RESETBAR) begin
    if (!RESETBAR) begin
      r_state    <= S_IDLE;
      r_live     <= 1'b0;
      r_cmd      <= '0;
      r_sz       <= '0;
      r_op       <= '0;
      r_addr     <= '0;
      r_din      <= '0;
      r_blw_sz   <= '0;
      r_blw_addr <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_req_hs) begin
            case (REQ_CMD)
              C_SCR: begin
                r_cmd   <= C_SCR;
                r_addr  <= REQ_ADDR;
                r_state <= S_ISSUE;
              end
              C_SCW: begin
                r_cmd   <= C_SCW;
                r_addr  <= REQ_ADDR;
                r_din   <= REQ_DATA;
                r_state <= S_ISSUE;
              end
              C_BLR: begin
                r_cmd   <= C_BLR;
                r_addr  <= REQ_ADDR;
                r_sz    <= REQ_SZ;
                r_state <= S_ISSUE;
              end
              C_BLW: begin
                r_blw_addr <= REQ_ADDR;
                r_blw_sz   <= REQ_SZ;
                r_wptr     <= '0;
                r_state    <= S_COLLECT;
              end
              C_ATR, C_ATW: begin
                r_cmd   <= REQ_CMD;
                r_addr  <= REQ_ADDR;
                r_sz    <= REQ_SZ;
                r_op    <= REQ_OP;
                r_din   <= REQ_DATA;
                r_state <= S_ISSUE;
              end
              default: begin
                // NOP (0/7) is dropped without touching the controller bus
              end
            endcase
          end
        end
        S_COLLECT: begin
          if (w_wdat_hs) begin
            r_wptr <= r_wptr + 5'd1;
            if (r_wptr == w_last_idx) begin
              // buf[0] was written at least 7 handshakes ago, so it is safe to read here
              r_cmd   <= C_BLW;
              r_addr  <= r_blw_addr;
              r_sz    <= r_blw_sz;
              r_din   <= r_buf[0];
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (w_consume) begin
            r_cmd  <= '0;
            r_sz   <= '0;
            r_op   <= '0;
            r_addr <= '0;
            if (r_cmd == C_BLW) begin
              // word 0 went out alongside the command; continue with word 1
              r_din   <= r_buf[1];
              r_rptr  <= 5'd1;
              r_state <= S_BLK_DATA;
            end else begin
              r_din   <= '0;
              r_state <= S_IDLE;
            end
          end
        end
        S_BLK_DATA: begin
          if (w_fill_ok) begin
            if (r_rptr == w_last_idx) begin
              r_din   <= '0;
              r_rptr  <= '0;
              r_state <= S_IDLE;
            end else begin
              r_rptr <= r_rptr + 5'd1;
              r_din  <= r_buf[r_rptr + 5'd1];
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Payload buffer: contents need no reset, only the write pointer does
  always_ff @(posedge CLK) begin
    if (w_wdat_hs) begin
      r_buf[r_wptr] <= WDATA;
    end
  end

`ifdef DDR2_SEQ_PERF_CNT_EN
  logic [15:0] r_issue_cnt;
  logic [15:0] r_stall_cnt;

  // Saturating counters of consumed commands and held command cycles
  always_ff @(posedge CLK or negedge RESETBAR) begin
    if (!RESETBAR) begin
      r_issue_cnt <= '0;
      r_stall_cnt <= '0;
    end else if (r_state == S_ISSUE) begin
      if (w_consume) begin
        if (r_issue_cnt != 16'hFFFF) r_issue_cnt <= r_issue_cnt + 16'd1;
      end else begin
        if (r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  assign ISSUE_CNT = r_issue_cnt;
  assign STALL_CNT = r_stall_cnt;
`else
  assign ISSUE_CNT = '0;
  assign STALL_CNT = '0;
`endif

endmodule

// File: doc/ddr2_host_req_sequencer.md
# ddr2_host_req_sequencer

Host-side request sequencer that sits directly upstream of `ddr2_controller` and drives its CMD/SZ/OP/ADDR/DIN inputs.
- Accepts one request at a time from a host valid/ready interface.
- Holds each command on the controller bus until the controller's FIFO flow-control signals show it consumed.
- Buffers block-write payloads in full, then streams them to the controller without bubbles.
- Replaces the hand-sequenced stimulus injection used at controller level with synthesizable logic.

## Interface
Parameters:
- `ADDR_W`, 25, request/controller address width
- `DATA_W`, 16, data word width
- `FILL_LIMIT`, 63, highest FILLCOUNT at which the controller data FIFO accepts a word

Ports:
- `CLK` in 1, single clock; all logic on the rising edge
- `RESETBAR` in 1, asynchronous, active-low reset
- `REQ_VALID` in 1, host request valid
- `REQ_READY` out 1, sequencer accepts a request this cycle
- `REQ_CMD` in 3, command: 0/7 NOP, 1 SCR, 2 SCW, 3 BLR, 4 BLW, 5 ATR, 6 ATW
- `REQ_SZ` in 2, block size; burst = 8*(SZ+1) words
- `REQ_OP` in 3, atomic opcode
- `REQ_ADDR` in ADDR_W, request address
- `REQ_DATA` in DATA_W, write data for SCW/ATR/ATW
- `WDATA_VALID` in 1, block-write payload word valid
- `WDATA_READY` out 1, sequencer accepts a payload word
- `WDATA` in DATA_W, block-write payload word
- `CTRL_READY` in 1, controller READY (initialisation complete)
- `NOTFULL` in 1, controller command FIFO has space
- `FILLCOUNT` in 7, controller data FIFO fill level
- `CMD` out 3, `SZ` out 2, `OP` out 3, `ADDR` out ADDR_W, `DIN` out DATA_W: registered controller inputs
- `BUSY` out 1, high in any state other than IDLE
- `ISSUE_CNT` out 16, commands consumed by the controller (see Configuration)
- `STALL_CNT` out 16, cycles CMD was held unconsumed (see Configuration)

## Operation
- States: IDLE, COLLECT, ISSUE, BLK_DATA.
- `REQ_READY` = (state==IDLE) && CTRL_READY.
- Request acceptance (REQ_VALID && REQ_READY at a rising edge):
  - NOP (0/7): dropped; stays IDLE; CMD remains 0.
  - BLW (4): latch ADDR/SZ; go to COLLECT.
  - Any other command: latch fields; go to ISSUE.
- COLLECT:
  - `WDATA_READY`=1.
  - Each WDATA handshake writes `buf[wptr]` and increments wptr.
  - When word N=8*(SZ+1) is written, go to ISSUE.
  - Buffer is 32 x DATA_W.
- ISSUE drives CMD=latched cmd, plus the fields each command uses:
  - SCR: ADDR.
  - SCW: ADDR, DIN=REQ_DATA.
  - BLR: ADDR, SZ.
  - BLW: ADDR, SZ, DIN=buf[0].
  - ATR/ATW: ADDR, SZ, OP, DIN.
  - Unused fields are driven 0.
- Consumption condition, evaluated at each rising edge while in ISSUE:
  - Reads (1,3): NOTFULL.
  - Writes (2,4,5,6): NOTFULL && FILLCOUNT<=FILL_LIMIT.
- On consumption:
  - Non-BLW: go to IDLE; all controller outputs return to 0.
  - BLW: go to BLK_DATA with CMD=0, DIN=buf[1], rptr=1.
- BLK_DATA: each edge with FILLCOUNT<=FILL_LIMIT consumes DIN and advances rptr. After word N-1 is consumed, go to IDLE with DIN=0.
- ISSUE without consumption: all outputs held unchanged; `STALL_CNT` increments.
- CTRL_READY falling: only blocks new acceptance. An in-flight command completes.
- Reset: async clear of state to IDLE and of wptr, rptr and counters. Buffer contents are don't-care; a partially collected burst is discarded.

## Timing
- Reset values: CMD=0, SZ=0, OP=0, ADDR=0, DIN=0, REQ_READY=0, WDATA_READY=0, BUSY=0, ISSUE_CNT=0, STALL_CNT=0.
- Accept edge T → CMD valid from T+1.
- With immediate consumption at edge T+1 → CMD=0 at T+2 → REQ_READY=1 at T+2.
- Peak throughput: one scalar command per 2 cycles.
- BLW: last WDATA edge T → CMD=4 from T+1.
- With no stalls, N words occupy DIN in N consecutive cycles. The first word is driven alongside CMD=4.
- FILLCOUNT boundary: FILLCOUNT==FILL_LIMIT permits consumption; FILL_LIMIT+1 stalls.
- WDATA_VALID gaps in COLLECT only lengthen COLLECT. The controller never sees a bubble.

## Configuration
- `DDR2_SEQ_PERF_CNT_EN` defined:
  - `ISSUE_CNT` increments on each consumed command (BLW counts once).
  - `STALL_CNT` increments per held cycle.
  - Both counters saturate at 16'hFFFF.
- Not defined: both outputs are tied to 0 and no counter flops are instantiated.

## Test plan
- Reset mid-BLW: RESETBAR low during COLLECT after 5 of 8 words → all outputs 0 asynchronously. After release, an SCR to 0x0000100 issues normally.
- SCR to ADDR 0x1BABAFE with NOTFULL=1 → CMD=1, ADDR=0x1BABAFE for exactly 1 cycle; ISSUE_CNT=1.
- SCW DATA 0xCAFE with FILLCOUNT=64 for 4 cycles, then 63 → CMD=2 held 5 cycles, consumed on the 5th edge; STALL_CNT=4 (macro on).
- BLW SZ=1 (16 words 0x0000..0x000F), WDATA_VALID toggling every other cycle → CMD=4 with DIN=0x0000, then 15 consecutive DIN words 0x0001..0x000F. No gaps while FILLCOUNT≤63.
- BLW SZ=3 with FILLCOUNT=64 asserted mid-burst for 3 cycles → DIN holds the current word for 3 cycles; total 32 words delivered in order.
- NOP and ATW (OP=5, SZ=2) back-to-back → NOP produces no CMD. ATW drives CMD=6, OP=5, SZ=2 until consumed.
